// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: shared FSM states, sizing constants and operand masking for the modular-multiply front end
package mod_arith_pkg;

    typedef enum logic [1:0] {IDLE, MUL, RED, OUT} state_e;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_DIGIT = 4;
    localparam int N         = DEF_WIDTH / DEF_DIGIT;
    localparam int CNT_W     = $clog2(N);
    localparam int MAX_W     = 1024;

    function automatic int steps(input int w, input int d);
        return w / d;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] mask_top(input logic [MAX_W-1:0] v, input int w);
        return v & ~(MAX_W'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/mod_mult_requester_mul_digit_step.sv
// mul_digit_step: one radix-2^DIGIT shift-add step, acc_o = (acc_i << DIGIT) + x_i * digit_i
module mul_digit_step #(
    parameter int width = 128,
    parameter int DIGIT = 4
) (
    input  logic [2*width-1:0] acc_i,
    input  logic [width-1:0]   x_i,
    input  logic [DIGIT-1:0]   digit_i,
    output logic [2*width-1:0] acc_o
);
    localparam int W2 = 2 * width;

    assign acc_o = (acc_i << DIGIT) + W2'(x_i) * W2'(digit_i);

endmodule

// File: rtl/mod_mult_requester.sv
// mod_mult_requester: shift-add modular-multiply front end that hands its product to an external reduction unit
module mod_mult_requester
    import mod_arith_pkg::*;
#(
    parameter int width = 128,
    parameter int DIGIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [width-1:0]          in_x,
    input  logic [width-1:0]          in_y,
    output logic                      red_enable,
    output logic signed [2*width-1:0] red_a,
    input  logic                      red_done,
    input  logic signed [width-1:0]   red_r,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          out_r,
    output logic                      busy
);
    localparam int NS = steps(width, DIGIT);
    localparam int CW = cnt_bits(NS);

    state_e             state_q, state_d;
    logic [width-1:0]   x_q, x_d, y_q, y_d, out_r_q, out_r_d;
    logic [2*width-1:0] acc_q, acc_d, acc_step;
    logic [CW-1:0]      cnt_q, cnt_d;

    // y is shifted left each MUL cycle so its top digit is always the next one to consume
    mul_digit_step #(.width(width), .DIGIT(DIGIT)) u_step (
        .acc_i   (acc_q),
        .x_i     (x_q),
        .digit_i (y_q[width-1 -: DIGIT]),
        .acc_o   (acc_step)
    );

    // next-state and datapath updates for the IDLE -> MUL -> RED -> OUT sequence
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_r_d = out_r_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                x_d     = width'(mask_top(MAX_W'(in_x), width));
                y_d     = width'(mask_top(MAX_W'(in_y), width));
                acc_d   = '0;
                cnt_d   = '0;
                state_d = MUL;
            end
            MUL: begin
                acc_d   = acc_step;
                y_d     = y_q << DIGIT;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(NS - 1)) ? RED : MUL;
            end
            RED: if (red_done) begin
                out_r_d = red_r[width-1:0];
                state_d = OUT;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_r_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_r_q <= out_r_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign red_enable = (state_q == RED);
    assign red_a      = acc_q;
    assign out_valid  = (state_q == OUT);
    assign out_r      = out_r_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mod_mult_requester.sv
// tb_mod_mult_requester: scoreboard bench for the modular-multiply front end with a mod-37 reduction stand-in
module tb_mod_mult_requester;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NS = W / D;
    localparam int P  = 37;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [W-1:0]          in_x = '0;
    logic [W-1:0]          in_y = '0;
    logic                  red_enable;
    logic signed [2*W-1:0] red_a;
    logic                  red_done = 1'b0;
    logic signed [W-1:0]   red_r = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [W-1:0]          out_r;
    logic                  busy;

    int checks = 0;
    int passed = 0;
    bit adapter_en = 1'b1;
    int delay_cfg = 0;
    int wait_cnt = 0;

    logic [2*W-1:0] a_q[$];
    logic [W-1:0]   r_q[$];

    mod_mult_requester #(.width(W), .DIGIT(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .red_enable (red_enable),
        .red_a      (red_a),
        .red_done   (red_done),
        .red_r      (red_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (adapter_en) begin
            if (red_enable) begin
                if (wait_cnt >= delay_cfg) begin
                    red_done = 1'b1;
                    red_r    = W'(int'(red_a) % P);
                end else begin
                    red_done = 1'b0;
                    wait_cnt++;
                end
            end else begin
                red_done = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] ea,
                          input logic [W-1:0] er, input int d, input int hold);
        int cyc;
        bit seen;
        logic [2*W-1:0] exp_a;
        logic [W-1:0] exp_r;
        a_q.push_back(ea);
        r_q.push_back(er);
        delay_cfg = d;
        exp_a = '0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL op_in_ready: got %b want 1", in_ready);
        else passed++;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (red_enable) begin
                if (!seen) begin
                    seen = 1'b1;
                    exp_a = a_q.pop_front();
                    checks++;
                    if (cyc !== NS + 1) $display("FAIL red_latency: got cycle %0d want %0d", cyc, NS + 1);
                    else passed++;
                end
                checks++;
                if (red_a !== exp_a) $display("FAIL red_a: got %0d want %0d (cycle %0d)", red_a, exp_a, cyc);
                else passed++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!out_valid || !seen) begin
            $display("FAIL out_timeout: out_valid=%b red_seen=%b after %0d cycles", out_valid, seen, cyc);
            if (seen) void'(r_q.pop_front());
            else begin
                void'(a_q.pop_front());
                void'(r_q.pop_front());
            end
            return;
        end
        passed++;
        exp_r = r_q.pop_front();
        checks++;
        if (cyc !== NS + 2 + d) $display("FAIL out_latency: got cycle %0d want %0d", cyc, NS + 2 + d);
        else passed++;
        checks++;
        if (red_enable !== 1'b0) $display("FAIL red_enable_drop: got %b want 0", red_enable);
        else passed++;
        checks++;
        if (out_r !== exp_r) $display("FAIL out_r: got %0d want %0d", out_r, exp_r);
        else passed++;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 3);
            in_x = 8'd1;
            in_y = 8'd1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_r !== exp_r || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL hold: out_valid=%b out_r=%0d in_ready=%b busy=%b want 1/%0d/0/1", out_valid, out_r, in_ready, busy, exp_r);
            else passed++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL release: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        else passed++;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (in_ready !== 1'b1 || red_enable !== 1'b0 || red_a !== '0 || out_valid !== 1'b0 || out_r !== '0 || busy !== 1'b0)
            $display("FAIL %s: in_ready=%b red_enable=%b red_a=%0d out_valid=%b out_r=%0d busy=%b want 1/0/0/0/0/0",
                     tag, in_ready, red_enable, red_a, out_valid, out_r, busy);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_op(8'd5, 8'd9, 16'd45, 8'd8, 0, 0);
        run_op(8'd36, 8'd36, 16'd1296, 8'd1, 3, 0);
        run_op(8'd0, 8'd17, 16'd0, 8'd0, 1, 0);
    endtask

    task automatic test_mask();
        run_op(8'h85, 8'd9, 16'd45, 8'd8, 2, 0);
    endtask

    task automatic test_backpressure();
        run_op(8'd5, 8'd9, 16'd45, 8'd8, 1, 10);
    endtask

    task automatic test_stub();
        adapter_en = 1'b0;
        @(negedge clk);
        red_done = 1'b1;
        red_r = 8'sd99;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_r !== 8'd8)
                $display("FAIL idle_done: in_ready=%b out_valid=%b busy=%b out_r=%0d want 1/0/0/8", in_ready, out_valid, busy, out_r);
            else passed++;
        end
        red_done = 1'b0;
        adapter_en = 1'b1;
        run_op(8'd10, 8'd11, 16'd110, 8'd36, 20, 0);
        run_op(8'd6, 8'd7, 16'd42, 8'd5, 0, 0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_x = 8'd7;
        in_y = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_reset");
        repeat (NS + 4) begin
            @(negedge clk);
            checks++;
            if (red_enable !== 1'b0 || busy !== 1'b0)
                $display("FAIL mid_reset_idle: red_enable=%b busy=%b want 0/0", red_enable, busy);
            else passed++;
        end
        run_op(8'd3, 8'd4, 16'd12, 8'd12, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_backpressure();
        test_stub();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
